// File: rtl/sprite_compositor.sv
// Pipelined sprite compositor: priority-encoded sprite hit, shared sprite RAM fetch, colour-keyed output.
// Optional sticky per-slot overlap flags when SPRITE_COLLISION_EN is defined.
module sprite_compositor #(
  parameter int unsigned NUM_SPRITES = 13,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned ADDR_W      = 19,
  parameter int unsigned COLOR_W     = 24,
  parameter int unsigned RAM_LAT     = 1,
  parameter logic [COLOR_W-1:0] TRANSPARENT = 24'hFF00FF,
  parameter logic [COLOR_W-1:0] BG_COLOR    = 24'h000000,
  parameter logic [COLOR_W-1:0] SOLID_COLOR = 24'hFFFF00
) (
  input  logic                           Clk,
  input  logic                           Reset,
  input  logic                           pixel_valid,
  input  logic [COORD_W-1:0]             DrawX,
  input  logic [COORD_W-1:0]             DrawY,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_x,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_y,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_w,
  input  logic [NUM_SPRITES*COORD_W-1:0] sprite_h,
  input  logic [NUM_SPRITES*ADDR_W-1:0]  sprite_base,
  input  logic [NUM_SPRITES-1:0]         sprite_en,
  input  logic [NUM_SPRITES-1:0]         sprite_solid,
  input  logic                           frame_start,
  output logic [ADDR_W-1:0]              rom_addr,
  input  logic [COLOR_W-1:0]             rom_data,
  output logic [7:0]                     Red,
  output logic [7:0]                     Green,
  output logic [7:0]                     Blue,
  output logic                           pixel_valid_out,
`ifdef SPRITE_COLLISION_EN
  output logic [NUM_SPRITES-1:0]         collision,
`endif
  output logic [$clog2(NUM_SPRITES+1)-1:0] hit_idx
);

  localparam int unsigned IDX_W = $clog2(NUM_SPRITES + 1);
  localparam int unsigned PW    = ((2 * COORD_W > ADDR_W) ? 2 * COORD_W : ADDR_W) + 1;
  localparam logic [IDX_W-1:0] NONE = IDX_W'(NUM_SPRITES);

  logic [NUM_SPRITES-1:0] covered;
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;
  logic                   win_solid;
  logic [COORD_W-1:0]     win_x, win_y, win_w;
  logic [ADDR_W-1:0]      win_base;
  logic [COORD_W-1:0]     dx, dy;
  logic [PW-1:0]          addr_full;
  logic [ADDR_W-1:0]      next_addr;

  // Edge sums are one bit wider so a sprite hanging off the right/bottom edge never wraps to 0.
  always_comb begin
    covered = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      logic [COORD_W:0] x0, y0, x1, y1, px, py;
      x0 = {1'b0, sprite_x[i*COORD_W +: COORD_W]};
      y0 = {1'b0, sprite_y[i*COORD_W +: COORD_W]};
      x1 = x0 + {1'b0, sprite_w[i*COORD_W +: COORD_W]};
      y1 = y0 + {1'b0, sprite_h[i*COORD_W +: COORD_W]};
      px = {1'b0, DrawX};
      py = {1'b0, DrawY};
      covered[i] = sprite_en[i]
                && (sprite_w[i*COORD_W +: COORD_W] != '0)
                && (sprite_h[i*COORD_W +: COORD_W] != '0)
                && (px >= x0) && (px < x1)
                && (py >= y0) && (py < y1);
    end
  end

  always_comb begin
    win_found = 1'b0;
    win_idx   = NONE;
    win_solid = 1'b0;
    win_x     = '0;
    win_y     = '0;
    win_w     = '0;
    win_base  = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (covered[i] && !win_found) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
        win_solid = sprite_solid[i];
        win_x     = sprite_x[i*COORD_W +: COORD_W];
        win_y     = sprite_y[i*COORD_W +: COORD_W];
        win_w     = sprite_w[i*COORD_W +: COORD_W];
        win_base  = sprite_base[i*ADDR_W +: ADDR_W];
      end
    end
    dx        = DrawX - win_x;
    dy        = DrawY - win_y;
    addr_full = PW'(win_base) + PW'(dy) * PW'(win_w) + PW'(dx);
    next_addr = (win_found && !win_solid) ? addr_full[ADDR_W-1:0] : '0;
  end

  // Stage k of the tag pipeline lines up with rom_data at k == RAM_LAT.
  logic [RAM_LAT:0] pv;
  logic [RAM_LAT:0] psolid;
  logic [IDX_W-1:0] pidx [RAM_LAT+1];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rom_addr <= '0;
      pv       <= '0;
      psolid   <= '0;
      for (int unsigned k = 0; k <= RAM_LAT; k++) pidx[k] <= NONE;
    end else begin
      rom_addr  <= next_addr;
      pv[0]     <= pixel_valid;
      psolid[0] <= win_solid;
      pidx[0]   <= win_idx;
      for (int unsigned k = 1; k <= RAM_LAT; k++) begin
        pv[k]     <= pv[k-1];
        psolid[k] <= psolid[k-1];
        pidx[k]   <= pidx[k-1];
      end
    end
  end

  logic [COLOR_W-1:0] rgb;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rgb             <= '0;
      pixel_valid_out <= 1'b0;
      hit_idx         <= NONE;
    end else if (!pv[RAM_LAT]) begin
      rgb             <= '0;
      pixel_valid_out <= 1'b0;
      hit_idx         <= NONE;
    end else begin
      pixel_valid_out <= 1'b1;
      hit_idx         <= pidx[RAM_LAT];
      if (pidx[RAM_LAT] == NONE)        rgb <= BG_COLOR;
      else if (psolid[RAM_LAT])         rgb <= SOLID_COLOR;
      else if (rom_data == TRANSPARENT) rgb <= BG_COLOR;
      else                              rgb <= rom_data;
    end
  end

  assign Red   = rgb[COLOR_W-1 -: 8];
  assign Green = rgb[COLOR_W-9 -: 8];
  assign Blue  = rgb[COLOR_W-17 -: 8];

`ifdef SPRITE_COLLISION_EN
  logic [NUM_SPRITES-1:0] overlap;
  logic [NUM_SPRITES-1:0] povl [RAM_LAT+1];

  // covered & (covered-1) is nonzero exactly when two or more slots are covered.
  always_comb begin
    overlap = ((covered & (covered - 1'b1)) != '0) ? covered : '0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned k = 0; k <= RAM_LAT; k++) povl[k] <= '0;
      collision <= '0;
    end else begin
      povl[0] <= overlap;
      for (int unsigned k = 1; k <= RAM_LAT; k++) povl[k] <= povl[k-1];
      if (frame_start)       collision <= '0;
      else if (pv[RAM_LAT])  collision <= collision | povl[RAM_LAT];
    end
  end
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor at default parameters (RAM_LAT=1) with a behavioural sprite RAM.
module tb_sprite_compositor;

  localparam int NS = 13;
  localparam int CW = 10;
  localparam int AW = 19;

  logic           Clk = 1'b0;
  logic           Reset = 1'b0;
  logic           pixel_valid = 1'b0;
  logic [CW-1:0]  DrawX = '0, DrawY = '0;
  logic [NS*CW-1:0] sprite_x, sprite_y, sprite_w, sprite_h;
  logic [NS*AW-1:0] sprite_base;
  logic [NS-1:0]  sprite_en = '0;
  logic [NS-1:0]  sprite_solid = '0;
  logic           frame_start = 1'b0;
  logic [AW-1:0]  rom_addr;
  logic [23:0]    rom_data = '0;
  logic [7:0]     Red, Green, Blue;
  logic           pixel_valid_out;
  logic [3:0]     hit_idx;
`ifdef SPRITE_COLLISION_EN
  logic [NS-1:0]  collision;
`endif

  logic [CW-1:0] sx [NS];
  logic [CW-1:0] sy [NS];
  logic [CW-1:0] sw [NS];
  logic [CW-1:0] sh [NS];
  logic [AW-1:0] sb [NS];

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  always_comb begin
    sprite_x = '0; sprite_y = '0; sprite_w = '0; sprite_h = '0; sprite_base = '0;
    for (int i = 0; i < NS; i++) begin
      sprite_x[i*CW +: CW]    = sx[i];
      sprite_y[i*CW +: CW]    = sy[i];
      sprite_w[i*CW +: CW]    = sw[i];
      sprite_h[i*CW +: CW]    = sh[i];
      sprite_base[i*AW +: AW] = sb[i];
    end
  end

  // Sprite RAM contents: address 0 and 0x3001 hold the colour key, everything else an address-derived word.
  function automatic logic [23:0] ram_word(input logic [AW-1:0] a);
    if (a == 19'h0 || a == 19'h3001) return 24'hFF00FF;
    return {5'h15, a};
  endfunction

  always @(posedge Clk) rom_data <= ram_word(rom_addr);

  sprite_compositor dut (
    .Clk(Clk), .Reset(Reset), .pixel_valid(pixel_valid),
    .DrawX(DrawX), .DrawY(DrawY),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sprite_w(sprite_w), .sprite_h(sprite_h),
    .sprite_base(sprite_base), .sprite_en(sprite_en), .sprite_solid(sprite_solid),
    .frame_start(frame_start), .rom_addr(rom_addr), .rom_data(rom_data),
    .Red(Red), .Green(Green), .Blue(Blue), .pixel_valid_out(pixel_valid_out),
`ifdef SPRITE_COLLISION_EN
    .collision(collision),
`endif
    .hit_idx(hit_idx)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk); #1;
  endtask

  // One isolated pixel: address one edge later, output exactly three edges after the pixel is presented.
  task automatic send(input string tag, input int x, input int y, input logic [AW-1:0] exp_addr,
                      input logic [23:0] exp_rgb, input logic [3:0] exp_idx);
    DrawX = CW'(x); DrawY = CW'(y); pixel_valid = 1'b1;
    tick();
    pixel_valid = 1'b0;
    chk({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
    chk({tag, ".pvo1"}, 32'(pixel_valid_out), 32'd0);
    tick();
    chk({tag, ".pvo2"}, 32'(pixel_valid_out), 32'd0);
    tick();
    chk({tag, ".pvo3"}, 32'(pixel_valid_out), 32'd1);
    chk({tag, ".rgb"}, 32'({Red, Green, Blue}), 32'(exp_rgb));
    chk({tag, ".idx"}, 32'(hit_idx), 32'(exp_idx));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NS; i++) begin
      sx[i] = '0; sy[i] = '0; sw[i] = '0; sh[i] = '0; sb[i] = '0;
    end
    sx[0] = 190;  sy[0] = 395; sw[0] = 20; sh[0] = 20; sb[0] = 19'h1000;
    sx[1] = 100;  sy[1] = 50;  sw[1] = 25; sh[1] = 25; sb[1] = 19'h0400;
    sx[2] = 300;  sy[2] = 300; sw[2] = 10; sh[2] = 10; sb[2] = 19'h3000;
    sx[3] = 195;  sy[3] = 398; sw[3] = 30; sh[3] = 30; sb[3] = 19'h2000;
    sx[4] = 700;  sy[4] = 700; sw[4] = 5;  sh[4] = 5;  sb[4] = 19'h6000;
    sx[5] = 704;  sy[5] = 704; sw[5] = 5;  sh[5] = 5;  sb[5] = 19'h7000;
    sx[6] = 1000; sy[6] = 10;  sw[6] = 40; sh[6] = 10; sb[6] = 19'h5000;
    sx[7] = 600;  sy[7] = 600; sw[7] = 0;  sh[7] = 10; sb[7] = 19'h4000;
    sx[12] = 500; sy[12] = 100; sw[12] = 4; sh[12] = 8; sb[12] = 19'h7F00;
    sprite_en    = 13'h10FF;
    sprite_solid = 13'h1000;

    // Reset held from time 0
    tick(); tick();
    chk("rst.pvo", 32'(pixel_valid_out), 32'd0);
    chk("rst.idx", 32'(hit_idx), 32'd13);
    chk("rst.addr", 32'(rom_addr), 32'd0);
    #3 Reset = 1'b1;
    tick();

    // Stream into slot 1, then assert reset asynchronously mid-cycle
    DrawX = 103; DrawY = 52; pixel_valid = 1'b1;
    tick(); tick(); tick();
    chk("stream.pvo", 32'(pixel_valid_out), 32'd1);
    #2 Reset = 1'b0;
    #1;
    chk("arst.pvo", 32'(pixel_valid_out), 32'd0);
    chk("arst.rgb", 32'({Red, Green, Blue}), 32'd0);
    chk("arst.idx", 32'(hit_idx), 32'd13);
    chk("arst.addr", 32'(rom_addr), 32'd0);
    tick();
    pixel_valid = 1'b0;
    #2 Reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("norestale.pvo", 32'(pixel_valid_out), 32'd0);
    end

    send("slot1",     103, 52,  19'h0435, ram_word(19'h0435), 4'd1);
    send("slot1.end", 124, 74,  19'h0670, ram_word(19'h0670), 4'd1);
    send("slot1.xedge", 125, 52, 19'h0,   24'h000000, 4'd13);
    send("prio0",     200, 400, 19'h106E, ram_word(19'h106E), 4'd0);
    sprite_en[0] = 1'b0;
    send("prio3",     200, 400, 19'h2041, ram_word(19'h2041), 4'd3);
    sprite_en[0] = 1'b1;
    send("transp",    301, 300, 19'h3001, 24'h000000, 4'd2);
    send("slot2",     302, 301, 19'h300C, ram_word(19'h300C), 4'd2);
    send("solid12",   501, 101, 19'h0,    24'hFFFF00, 4'd12);
    send("wide",      1020, 15, 19'h50DC, ram_word(19'h50DC), 4'd6);
    send("nowrap",    0,   15,  19'h0,    24'h000000, 4'd13);
    send("zerow",     600, 605, 19'h0,    24'h000000, 4'd13);
    sprite_en[1] = 1'b0;
    send("disabled",  103, 52,  19'h0,    24'h000000, 4'd13);
    sprite_en[1] = 1'b1;

    // Back-to-back pixels, one per clock
    DrawX = 103; DrawY = 52; pixel_valid = 1'b1; tick();
    DrawX = 301; DrawY = 300; tick();
    DrawX = 501; DrawY = 101; tick();
    pixel_valid = 1'b0;
    chk("b2b.a.rgb", 32'({Red, Green, Blue}), 32'(ram_word(19'h0435)));
    chk("b2b.a.idx", 32'(hit_idx), 32'd1);
    tick();
    chk("b2b.b.rgb", 32'({Red, Green, Blue}), 32'd0);
    chk("b2b.b.idx", 32'(hit_idx), 32'd2);
    chk("b2b.b.pvo", 32'(pixel_valid_out), 32'd1);
    tick();
    chk("b2b.c.rgb", 32'({Red, Green, Blue}), 32'hFFFF00);
    chk("b2b.c.idx", 32'(hit_idx), 32'd12);
    tick();
    chk("b2b.bubble.pvo", 32'(pixel_valid_out), 32'd0);
    chk("b2b.bubble.rgb", 32'({Red, Green, Blue}), 32'd0);

`ifdef SPRITE_COLLISION_EN
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("col.clear0", 32'(collision), 32'd0);
    send("col.single", 700, 700, 19'h6000, ram_word(19'h6000), 4'd4);
    chk("col.single", 32'(collision), 32'd0);
    send("col.overlap", 704, 704, 19'h6018, ram_word(19'h6018), 4'd4);
    chk("col.set", 32'(collision), 32'h0030);
    tick(); tick(); tick();
    chk("col.hold", 32'(collision), 32'h0030);
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("col.clear", 32'(collision), 32'd0);
    DrawX = 704; DrawY = 704; pixel_valid = 1'b1; tick();
    pixel_valid = 1'b0; tick();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    chk("col.fs_wins.pvo", 32'(pixel_valid_out), 32'd1);
    chk("col.fs_wins", 32'(collision), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
